// File: rtl/apb_fifo_slave_pkg.sv
// -----------------------------------------------------------------------------
// apb_fifo_slave_pkg
//   Shared definitions for the APB FIFO slave: register word offsets
//   (PADDR[3:2]), STATUS/CTRL bit positions and field ranges, the wait-state
//   FSM encoding, and helpers that assemble the STATUS and CTRL read words.
//   Imported by sync_fifo and apb_fifo_slave.
// -----------------------------------------------------------------------------
package apb_fifo_slave_pkg;

    // Register word offsets as seen on PADDR[3:2]
    localparam logic [1:0] ADDR_DATA   = 2'd0;  // 0x0
    localparam logic [1:0] ADDR_STATUS = 2'd1;  // 0x4
    localparam logic [1:0] ADDR_CTRL   = 2'd2;  // 0x8
    localparam logic [1:0] ADDR_RSVD   = 2'd3;  // 0xC

    // STATUS fields
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_UNF_BIT   = 3;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_MSB = 15;

    // CTRL fields
    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_THRESH_LSB = 8;
    localparam int CTRL_THRESH_MSB = 15;

    // Wait-state FSM (used only when APB_FIFO_WAIT_EN is defined)
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic       unf,
                                                input logic [7:0] level);
        logic [31:0] word;
        word                                = '0;
        word[STAT_EMPTY_BIT]                = empty;
        word[STAT_FULL_BIT]                 = full;
        word[STAT_OVF_BIT]                  = ovf;
        word[STAT_UNF_BIT]                  = unf;
        word[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level;
        return word;
    endfunction

    // FLUSH is self-clearing, so it always reads back as 0.
    function automatic logic [31:0] pack_ctrl(input logic       irq_en,
                                              input logic [7:0] thresh);
        logic [31:0] word;
        word                                  = '0;
        word[CTRL_IRQ_EN_BIT]                 = irq_en;
        word[CTRL_THRESH_MSB:CTRL_THRESH_LSB] = thresh;
        return word;
    endfunction

endpackage

// File: rtl/apb_fifo_slave_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO of 2^DEPTH_LOG2 words. A push while full and a pop while
//   empty are ignored; the caller decides what that means (overflow/underflow
//   flags). Flush empties the FIFO and takes priority over push/pop.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i          write wdata_i at the tail (ignored when full)
//   pop_i           advance the head (ignored when empty)
//   flush_i         reset pointers and level to 0
//   wdata_i         write data
//   head_o          word at the head (undefined content when empty)
//   level_o         current occupancy, 0..2^DEPTH_LOG2
//   level_next_o    occupancy after this cycle's push/pop/flush
//   full_o, empty_o occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo
    import apb_fifo_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [DEPTH_LOG2:0]   level_next_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                     DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]    FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]    LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q,  level_d;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // Pointers are DEPTH_LOG2 bits wide, so +1 wraps modulo depth for free.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LEVEL_ONE;
                2'b01:   level_d = level_q - LEVEL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array has no reset; level/pointers gate every read, so
    // stale contents are never observable and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/apb_fifo_slave.sv
// -----------------------------------------------------------------------------
// apb_fifo_slave
//   APB responder exposing a 32-bit FIFO as registers:
//     0x0 DATA   write pushes, read pops (empty read returns 0, sets UNF)
//     0x4 STATUS EMPTY/FULL/OVF/UNF/LEVEL, OVF/UNF are write-1-to-clear
//     0x8 CTRL   FLUSH (self-clearing), IRQ_EN, THRESH
//     0xC reserved, reads 0
//   IRQ is a registered level: IRQ_EN & (OVF | UNF | LEVEL >= THRESH != 0),
//   computed from the state a commit leaves behind.
//
// Configuration macro: APB_FIFO_WAIT_EN
//   undefined - zero wait states, PREADY tied 1, PRDATA combinational.
//   defined   - ST_IDLE/ST_WAIT FSM inserts exactly one wait state per
//               transfer, PRDATA registered, PREADY resets to 0.
//
// Ports
//   PCLK, PRESETn          APB clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR[31:0]            byte address, only [3:2] decoded
//   PWDATA[31:0]           write data
//   PRDATA[31:0]           read data (valid when PSEL&PENABLE&PREADY)
//   PREADY                 transfer completion
//   IRQ                    level interrupt
// -----------------------------------------------------------------------------
module apb_fifo_slave
    import apb_fifo_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ
);

    logic                access;
    logic                commit;
    logic                wr_cmt, rd_cmt;
    logic                sel_data, sel_status, sel_ctrl;
    logic                fifo_push, fifo_pop, fifo_flush;
    logic [31:0]         fifo_head;
    logic [DEPTH_LOG2:0] fifo_level, fifo_level_next;
    logic                fifo_full, fifo_empty;
    logic [31:0]         rd_data;

    logic                ovf_q,    ovf_d;
    logic                unf_q,    unf_d;
    logic                irq_en_q, irq_en_d;
    logic [7:0]          thresh_q, thresh_d;
    logic                irq_q,    irq_d;

    // Address bits outside [3:2] are intentionally ignored.
    logic                unused_paddr;
    assign unused_paddr = ^{PADDR[31:4], PADDR[1:0]};

    assign access     = PSEL & PENABLE;
    assign sel_data   = (PADDR[3:2] == ADDR_DATA);
    assign sel_status = (PADDR[3:2] == ADDR_STATUS);
    assign sel_ctrl   = (PADDR[3:2] == ADDR_CTRL);

    // Read mux: what the addressed register holds right now.
    always_comb begin
        rd_data = '0;
        case (PADDR[3:2])
            ADDR_DATA:   rd_data = fifo_empty ? '0 : fifo_head;
            ADDR_STATUS: rd_data = pack_status(fifo_empty, fifo_full, ovf_q, unf_q,
                                               8'(fifo_level));
            ADDR_CTRL:   rd_data = pack_ctrl(irq_en_q, thresh_q);
            default:     rd_data = '0;
        endcase
    end

`ifdef APB_FIFO_WAIT_EN
    state_e      state_q,  state_d;
    logic        pready_q, pready_d;
    logic [31:0] prdata_q, prdata_d;

    // The first access cycle (ST_IDLE) captures read data and holds PREADY
    // low; the second (ST_WAIT) raises PREADY and commits. If PSEL/PENABLE
    // drop in ST_WAIT the transfer is abandoned without a commit.
    always_comb begin
        state_d  = state_q;
        pready_d = 1'b0;
        prdata_d = prdata_q;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    state_d  = ST_WAIT;
                    pready_d = 1'b1;
                    prdata_d = rd_data;
                end
            end
            ST_WAIT: begin
                state_d = ST_IDLE;
                commit  = access;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;
`else
    assign commit = access;
    assign PREADY = 1'b1;
    assign PRDATA = access ? rd_data : '0;
`endif

    assign wr_cmt     = commit &  PWRITE;
    assign rd_cmt     = commit & ~PWRITE;
    assign fifo_push  = wr_cmt & sel_data;
    assign fifo_pop   = rd_cmt & sel_data;
    assign fifo_flush = wr_cmt & sel_ctrl & PWDATA[CTRL_FLUSH_BIT];

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk          (PCLK),
        .rst_n        (PRESETn),
        .push_i       (fifo_push),
        .pop_i        (fifo_pop),
        .flush_i      (fifo_flush),
        .wdata_i      (PWDATA),
        .head_o       (fifo_head),
        .level_o      (fifo_level),
        .level_next_o (fifo_level_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Flags and control. A single commit touches only one register, so a W1C
    // clear and a set of the same flag can never coincide.
    always_comb begin
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;

        if (wr_cmt && sel_status && PWDATA[STAT_OVF_BIT]) ovf_d = 1'b0;
        if (wr_cmt && sel_status && PWDATA[STAT_UNF_BIT]) unf_d = 1'b0;
        if (fifo_push && fifo_full)  ovf_d = 1'b1;
        if (fifo_pop  && fifo_empty) unf_d = 1'b1;

        if (wr_cmt && sel_ctrl) begin
            irq_en_d = PWDATA[CTRL_IRQ_EN_BIT];
            thresh_d = PWDATA[CTRL_THRESH_MSB:CTRL_THRESH_LSB];
        end

        // Evaluated on the post-commit values so IRQ follows the commit by
        // exactly one cycle.
        irq_d = irq_en_d & (ovf_d | unf_d |
                            ((thresh_d != 8'd0) && (8'(fifo_level_next) >= thresh_d)));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_fifo_slave
//   Directed bench for apb_fifo_slave (DEPTH_LOG2 = 4). Works with or without
//   APB_FIFO_WAIT_EN; the expected wait-state count follows the macro.
// -----------------------------------------------------------------------------
module tb_apb_fifo_slave;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_CTRL   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;

`ifdef APB_FIFO_WAIT_EN
    localparam int          EXP_WAITS  = 1;
    localparam logic [31:0] EXP_PREADY = 32'd0;
`else
    localparam int          EXP_WAITS  = 0;
    localparam logic [31:0] EXP_PREADY = 32'd1;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    always #5 PCLK = ~PCLK;

    apb_fifo_slave #(.DEPTH_LOG2(4)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .IRQ     (IRQ)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer: setup cycle, then access until PREADY (bounded).
    // Returns one cycle after the commit edge, so state and IRQ are updated.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int waits;
        waits   = 0;
        rdata   = '0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        forever begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                rdata = PRDATA;
                break;
            end
            waits++;
            if (waits > 8) break;
            @(posedge PCLK); #1;
        end
        check("pready_waits", 32'(waits), 32'(EXP_WAITS));
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, wdata, dummy);
    endtask

    task automatic apb_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rdata;
        apb_xfer(1'b0, addr, 32'h0, rdata);
        check(tag, rdata, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn = 1'b0;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);

        // ---- Reset state
        check("rst_pready", 32'(PREADY), EXP_PREADY);
        check("rst_irq",    32'(IRQ),    32'd0);
        check("rst_prdata", PRDATA,      32'd0);
        apb_rd_chk("rst_status", A_STATUS, 32'h0000_0001);
        apb_rd_chk("rst_ctrl",   A_CTRL,   32'h0000_0000);

        // ---- Basic push/pop ordering
        apb_wr(A_DATA, 32'h11);
        apb_wr(A_DATA, 32'h22);
        apb_wr(A_DATA, 32'h33);
        apb_rd_chk("status_lvl3", A_STATUS, 32'h0000_0300);
        apb_rd_chk("pop_11", A_DATA, 32'h11);
        apb_rd_chk("pop_22", A_DATA, 32'h22);
        apb_rd_chk("pop_33", A_DATA, 32'h33);
        apb_rd_chk("status_lvl0", A_STATUS, 32'h0000_0001);

        // ---- Fill past capacity (pointers wrap), word 17 dropped
        for (int i = 1; i <= 17; i++) apb_wr(A_DATA, 32'(i));
        apb_rd_chk("status_full_ovf", A_STATUS, 32'h0000_1006);
        for (int i = 1; i <= 16; i++) apb_rd_chk("pop_fill", A_DATA, 32'(i));
        apb_rd_chk("status_drained_ovf", A_STATUS, 32'h0000_0005);
        apb_wr(A_STATUS, 32'h4);
        apb_rd_chk("status_ovf_cleared", A_STATUS, 32'h0000_0001);

        // ---- Reserved register and setup-only cycles have no effect
        apb_wr(A_RSVD, 32'hFFFF_FFFF);
        apb_rd_chk("rsvd_read", A_RSVD, 32'h0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DATA; PWDATA = 32'hBAD;
        repeat (2) @(posedge PCLK);
        #1 PSEL = 1'b0; PWRITE = 1'b0;
        apb_rd_chk("setup_only_no_push", A_STATUS, 32'h0000_0001);

        // ---- Underflow and interrupt
        apb_wr(A_CTRL, 32'h0000_0002);
        check("irq_en_no_flag", 32'(IRQ), 32'd0);
        apb_rd_chk("pop_empty", A_DATA, 32'h0);
        check("irq_unf", 32'(IRQ), 32'd1);
        apb_rd_chk("status_unf", A_STATUS, 32'h0000_0009);
        apb_wr(A_STATUS, 32'h8);
        check("irq_unf_cleared", 32'(IRQ), 32'd0);
        apb_rd_chk("status_unf_cleared", A_STATUS, 32'h0000_0001);

        // ---- Threshold interrupt and flush
        apb_wr(A_CTRL, 32'h0000_0402);
        apb_rd_chk("ctrl_readback", A_CTRL, 32'h0000_0402);
        apb_wr(A_DATA, 32'hA1);
        apb_wr(A_DATA, 32'hA2);
        apb_wr(A_DATA, 32'hA3);
        check("irq_lvl3_below", 32'(IRQ), 32'd0);
        apb_wr(A_DATA, 32'hA4);
        check("irq_lvl4_thresh", 32'(IRQ), 32'd1);
        apb_rd_chk("status_lvl4", A_STATUS, 32'h0000_0400);
        apb_wr(A_CTRL, 32'h0000_0403);
        check("irq_after_flush", 32'(IRQ), 32'd0);
        apb_rd_chk("status_flushed", A_STATUS, 32'h0000_0001);
        apb_rd_chk("ctrl_flush_selfclr", A_CTRL, 32'h0000_0402);
        apb_wr(A_DATA, 32'hB1);
        apb_rd_chk("pop_after_flush", A_DATA, 32'hB1);

`ifdef APB_FIFO_WAIT_EN
        // ---- PSEL dropped in ST_WAIT: no commit
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DATA; PWDATA = 32'hC1;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        check("wait_pready_high", 32'(PREADY), 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        check("abort_pready_low", 32'(PREADY), 32'd0);
        apb_rd_chk("abort_no_push", A_STATUS, 32'h0000_0001);

        // ---- Reset asserted in ST_WAIT of a DATA write: no push
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DATA; PWDATA = 32'hD1;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #2;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_rd_chk("rst_in_wait_no_push", A_STATUS, 32'h0000_0001);
`endif

        // ---- Asynchronous reset clears FIFO and control
        apb_wr(A_DATA, 32'hE1);
        apb_wr(A_CTRL, 32'h0000_0102);
        check("irq_before_reset", 32'(IRQ), 32'd1);
        #2 PRESETn = 1'b0;
        #1;
        check("irq_async_reset", 32'(IRQ), 32'd0);
        @(posedge PCLK); #1 PRESETn = 1'b1;
        apb_rd_chk("status_after_reset", A_STATUS, 32'h0000_0001);
        apb_rd_chk("ctrl_after_reset", A_CTRL, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
